// File: rtl/abz_pkg.sv
// Shared definitions for the ABZ encoder chain: FSM states, step encodings and
// the count width shared with the quadrature counter stage.
package abz_pkg;

    localparam int ABZ_BIT_LENGTH = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // Two's-complement step codes so the accumulator can sign-extend them.
    localparam logic [1:0] STEP_0  = 2'b00;
    localparam logic [1:0] STEP_P1 = 2'b01;
    localparam logic [1:0] STEP_M1 = 2'b11;

endpackage

// File: rtl/abz_step_decode.sv
// Combinational decode of one count step: +1, -1, 0, or a discontinuity.
// Differences are taken modulo 2^BIT_LENGTH so counter wrap decodes as a step.
module abz_step_decode
    import abz_pkg::*;
#(
    parameter int BIT_LENGTH = ABZ_BIT_LENGTH
)(
    input  logic [BIT_LENGTH-1:0] i_prev,
    input  logic [BIT_LENGTH-1:0] i_cnt,
    output logic [1:0]            o_step,
    output logic                  o_jump
);

    logic [BIT_LENGTH-1:0] w_diff;

    assign w_diff = i_cnt - i_prev;

    always_comb begin
        o_step = STEP_0;
        o_jump = 1'b0;
        if (w_diff == BIT_LENGTH'(1)) begin
            o_step = STEP_P1;
        end else if (w_diff == '1) begin
            o_step = STEP_M1;
        end else if (w_diff != '0) begin
            o_jump = 1'b1;
        end
    end

endmodule

// File: rtl/abz_speed_meas.sv
// Windowed speed measurement behind the ABZ counter: sums count steps over
// WIN_LEN clocks and reports a saturated signed speed with status flags.
module abz_speed_meas
    import abz_pkg::*;
#(
    parameter int BIT_LENGTH    = ABZ_BIT_LENGTH,
    parameter int WIN_WIDTH     = 16,
    parameter int ACC_WIDTH     = 16,
    parameter int STILL_WINDOWS = 4
)(
    input  logic                  CLK,
    input  logic                  ARSTN,
    input  logic                  EN,
    input  logic [BIT_LENGTH-1:0] CNT_IN,
    input  logic [WIN_WIDTH-1:0]  WIN_LEN,
    output logic [ACC_WIDTH-1:0]  SPEED_OUT,
    output logic                  SPEED_VALID,
    output logic                  DIR_OUT,
    output logic                  STANDSTILL,
    output logic                  JUMP_FLAG,
    output logic                  SAT_FLAG
);

    localparam int SC_W = $clog2(STILL_WINDOWS + 1);
    localparam logic [SC_W-1:0] C_STILL = SC_W'(STILL_WINDOWS);
    localparam logic signed [ACC_WIDTH:0] C_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] C_MIN = -C_MAX;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [BIT_LENGTH-1:0]        r_prev;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [WIN_WIDTH-1:0]         r_wcnt;
    logic                         r_jump_seen;
    logic                         r_sat_seen;
    logic [SC_W-1:0]              r_still;

    logic [1:0]                   w_step;
    logic                         w_jump;
    logic signed [ACC_WIDTH:0]    w_step_ext;
    logic signed [ACC_WIDTH:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]  w_acc_sat;
    logic                         w_clip;
    logic                         w_win_zero;
    logic                         w_terminal;

    abz_step_decode #(
        .BIT_LENGTH (BIT_LENGTH)
    ) u_step_decode (
        .i_prev (r_prev),
        .i_cnt  (CNT_IN),
        .o_step (w_step),
        .o_jump (w_jump)
    );

    assign w_win_zero = (WIN_LEN == '0);
    assign w_terminal = (r_state == MEASURE) && EN && (r_wcnt == '0);

    always_comb begin
        w_step_ext = '0;
        if (w_step == STEP_P1) begin
            w_step_ext = (ACC_WIDTH+1)'(1);
        end else if (w_step == STEP_M1) begin
            w_step_ext = '1;
        end
    end

    // One guard bit lets the sum be compared against the symmetric limits.
    assign w_sum  = $signed({r_acc[ACC_WIDTH-1], r_acc}) + w_step_ext;
    assign w_clip = (w_sum > C_MAX) || (w_sum < C_MIN);

    always_comb begin
        w_acc_sat = w_sum[ACC_WIDTH-1:0];
        if (w_sum > C_MAX) begin
            w_acc_sat = C_MAX[ACC_WIDTH-1:0];
        end else if (w_sum < C_MIN) begin
            w_acc_sat = C_MIN[ACC_WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (EN && !w_win_zero) w_state_next = PRIME;
            PRIME:   w_state_next = (EN && !w_win_zero) ? MEASURE : IDLE;
            MEASURE: if (!EN || (w_terminal && w_win_zero)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_prev      <= '0;
            r_acc       <= '0;
            r_wcnt      <= '0;
            r_jump_seen <= 1'b0;
            r_sat_seen  <= 1'b0;
            r_still     <= '0;
            SPEED_OUT   <= '0;
            SPEED_VALID <= 1'b0;
            DIR_OUT     <= 1'b0;
            STANDSTILL  <= 1'b0;
            JUMP_FLAG   <= 1'b0;
            SAT_FLAG    <= 1'b0;
        end else begin
            r_prev      <= CNT_IN;
            SPEED_VALID <= 1'b0;
            case (r_state)
                PRIME: begin
                    r_acc       <= '0;
                    r_jump_seen <= 1'b0;
                    r_sat_seen  <= 1'b0;
                    r_wcnt      <= WIN_LEN - 1'b1;
                end
                MEASURE: begin
                    // With EN low the partial window is simply abandoned.
                    if (w_terminal) begin
                        SPEED_OUT   <= w_acc_sat;
                        JUMP_FLAG   <= r_jump_seen | w_jump;
                        SAT_FLAG    <= r_sat_seen | w_clip;
                        SPEED_VALID <= 1'b1;
                        if (w_acc_sat != '0) begin
                            DIR_OUT    <= ~w_acc_sat[ACC_WIDTH-1];
                            r_still    <= '0;
                            STANDSTILL <= 1'b0;
                        end else if (r_still != C_STILL) begin
                            r_still    <= r_still + 1'b1;
                            STANDSTILL <= ((r_still + 1'b1) == C_STILL);
                        end
                        r_acc       <= '0;
                        r_jump_seen <= 1'b0;
                        r_sat_seen  <= 1'b0;
                        r_wcnt      <= WIN_LEN - 1'b1;
                    end else if (EN) begin
                        r_acc       <= w_acc_sat;
                        r_jump_seen <= r_jump_seen | w_jump;
                        r_sat_seen  <= r_sat_seen | w_clip;
                        r_wcnt      <= r_wcnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_abz_speed_meas.sv
// Scoreboard bench for abz_speed_meas: expected windows are queued as stimulus
// is driven and compared (value and cycle) when SPEED_VALID strobes.
module tb_abz_speed_meas;

    logic        CLK = 1'b0;
    logic        ARSTN;
    logic        EN;
    logic [11:0] CNT_IN;
    logic [15:0] WIN_LEN;

    logic [15:0] speed;
    logic        valid, dir, still, jump, sat;
    logic [3:0]  speed_s;
    logic        valid_s, dir_s, still_s, jump_s, sat_s;

    typedef struct {
        int cyc;
        int speed;
        bit dir;
        bit still;
        bit jump;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   m_dir = 0;
    int   m_still = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    abz_speed_meas dut (
        .CLK(CLK), .ARSTN(ARSTN), .EN(EN), .CNT_IN(CNT_IN), .WIN_LEN(WIN_LEN),
        .SPEED_OUT(speed), .SPEED_VALID(valid), .DIR_OUT(dir),
        .STANDSTILL(still), .JUMP_FLAG(jump), .SAT_FLAG(sat)
    );

    abz_speed_meas #(.ACC_WIDTH(4)) dut_s (
        .CLK(CLK), .ARSTN(ARSTN), .EN(EN), .CNT_IN(CNT_IN), .WIN_LEN(WIN_LEN),
        .SPEED_OUT(speed_s), .SPEED_VALID(valid_s), .DIR_OUT(dir_s),
        .STANDSTILL(still_s), .JUMP_FLAG(jump_s), .SAT_FLAG(sat_s)
    );

    task automatic chk(string tag, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Expected window result; dir/standstill follow from the window history.
    task automatic push_win(int c, int spd, bit jmp);
        exp_t e;
        if (spd != 0) begin
            m_dir   = (spd > 0) ? 1 : 0;
            m_still = 0;
        end else if (m_still < 4) begin
            m_still++;
        end
        e.cyc   = c;
        e.speed = spd;
        e.dir   = (m_dir != 0);
        e.still = (m_still == 4);
        e.jump  = jmp;
        exp_q.push_back(e);
    endtask

    // Raise EN at a negedge; the next posedge is the one that samples it.
    task automatic start(int n, output int e0);
        @(negedge CLK);
        WIN_LEN = 16'(n);
        EN      = 1'b1;
        e0      = cyc + 1;
    endtask

    task automatic drive(int vals[$]);
        foreach (vals[i]) begin
            @(negedge CLK);
            CNT_IN = 12'(vals[i]);
        end
    endtask

    task automatic stop();
        @(negedge CLK);
        EN = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        int   exp_s;
        if (valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                exp_s = (e.speed > 7) ? 7 : ((e.speed < -7) ? -7 : e.speed);
                $display("window @%0d: speed=%0d dir=%0d still=%0d jump=%0d sat=%0d | small speed=%0d sat=%0d",
                         cyc, $signed(speed), dir, still, jump, sat, $signed(speed_s), sat_s);
                chk("valid_cycle", cyc, e.cyc);
                chk("speed", $signed(speed), e.speed);
                chk("dir", int'(dir), int'(e.dir));
                chk("standstill", int'(still), int'(e.still));
                chk("jump", int'(jump), int'(e.jump));
                chk("sat", int'(sat), 0);
                chk("valid_small", int'(valid_s), 1);
                chk("speed_small", $signed(speed_s), exp_s);
                chk("sat_small", int'(sat_s), (e.speed > 7 || e.speed < -7) ? 1 : 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v[$];
        int e0;

        ARSTN = 1'b0; EN = 1'b0; CNT_IN = '0; WIN_LEN = '0;
        repeat (3) @(negedge CLK);
        chk("rst_speed", int'(speed), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_still", int'(still), 0);
        chk("rst_jump", int'(jump), 0);
        chk("rst_sat", int'(sat), 0);
        ARSTN = 1'b1;
        repeat (2) @(negedge CLK);

        // +1 every 4 clocks, two back-to-back windows of 100
        CNT_IN = 0;
        start(100, e0);
        push_win(e0 + 101, 25, 0);
        push_win(e0 + 201, 25, 0);
        v = {};
        for (int k = 1; k <= 201; k++) v.push_back(k / 4);
        drive(v);
        stop();

        // counting down through the wrap
        CNT_IN = 2;
        start(5, e0);
        push_win(e0 + 6, -4, 0);
        v = {2, 2, 1, 0, 4095, 4094};
        drive(v);
        stop();

        // Z clear 37 -> 0 mid-window, then a clean window
        CNT_IN = 34;
        start(10, e0);
        push_win(e0 + 11, 4, 1);
        push_win(e0 + 21, 5, 0);
        v = {34, 35, 35, 36, 36, 37, 37, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6};
        drive(v);
        stop();

        // +1 per clock: saturates the 4-bit instance
        CNT_IN = 0;
        start(20, e0);
        push_win(e0 + 21, 20, 0);
        v = {};
        for (int k = 1; k <= 21; k++) v.push_back(k);
        drive(v);
        stop();

        // standstill after 4 zero windows, cleared by a +1 window
        CNT_IN = 100;
        start(8, e0);
        for (int w = 1; w <= 5; w++) push_win(e0 + 8 * w + 1, 0, 0);
        push_win(e0 + 49, 1, 0);
        v = {};
        for (int k = 1; k <= 49; k++) v.push_back(k <= 44 ? 100 : 101);
        drive(v);
        stop();

        // EN dropped mid-window: no strobe, outputs hold
        CNT_IN = 0;
        start(100, e0);
        v = {};
        for (int k = 1; k <= 50; k++) v.push_back(k / 4);
        drive(v);
        stop();
        repeat (10) @(negedge CLK);
        chk("hold_speed", $signed(speed), 1);
        chk("hold_dir", int'(dir), 1);
        chk("hold_still", int'(still), 0);

        // EN re-raised: first strobe 101 clocks after the sampling edge
        start(100, e0);
        push_win(e0 + 101, 25, 0);
        v = {};
        for (int k = 1; k <= 101; k++) v.push_back(12 + k / 4);
        drive(v);
        stop();

        // asynchronous reset mid-window
        CNT_IN = 0;
        start(100, e0);
        v = {};
        for (int k = 1; k <= 30; k++) v.push_back(k);
        drive(v);
        #2 ARSTN = 1'b0;
        #1;
        chk("arst_speed", int'(speed), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_dir", int'(dir), 0);
        chk("arst_still", int'(still), 0);
        chk("arst_jump", int'(jump), 0);
        chk("arst_sat", int'(sat), 0);
        m_dir = 0;
        m_still = 0;
        EN = 1'b0;
        @(negedge CLK);
        ARSTN = 1'b1;
        repeat (2) @(negedge CLK);

        // recovery after reset: a zero window
        CNT_IN = 7;
        start(5, e0);
        push_win(e0 + 6, 0, 0);
        v = {7, 7, 7, 7, 7, 7};
        drive(v);
        stop();

        repeat (5) @(negedge CLK);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
